// File: rtl/wormhole_out_arb_pkg.sv
// wormhole_out_arb_pkg: shared flit-type codes, router sizing and output-arbiter state type
package wormhole_out_arb_pkg;
  localparam int FLIT_LENGTH = 32;
  localparam int NUM_PORTS = 5;
  localparam int FLIT_TYPE_MSB = FLIT_LENGTH - 1;
  localparam int FLIT_TYPE_LSB = FLIT_LENGTH - 2;
  localparam logic [1:0] FLIT_TYPE_BODY = 2'b00;
  localparam logic [1:0] FLIT_TYPE_TAIL = 2'b01;
  localparam logic [1:0] FLIT_TYPE_HEAD = 2'b10;
  localparam logic [1:0] FLIT_TYPE_SINGLE = 2'b11;
  typedef enum logic {IDLE, LOCKED} state_t;
endpackage

// File: rtl/wormhole_out_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr with wrap
module rr_pick #(
  parameter int N = 5,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    // scan from farthest to nearest so the closest request to ptr wins last
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/wormhole_out_arb.sv
// wormhole_out_arb: wormhole output-port arbiter, round-robin head grant with lock until tail
module wormhole_out_arb
  import wormhole_out_arb_pkg::*;
#(
  parameter int NUM_IN = NUM_PORTS,
  parameter int FLIT_W = FLIT_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        in_empty,
  input  logic [NUM_IN*FLIT_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_req,
  output logic [NUM_IN-1:0]        in_pop,
  output logic [FLIT_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     lock_busy,
  output logic                     proto_err
);
  localparam int IW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;
  state_t state, state_n;
  logic [IW-1:0] owner, owner_n, rr_ptr, rr_n, pick_idx, sel_idx;
  logic [NUM_IN-1:0] elig, pick_grant;
  logic [FLIT_W-1:0] sel_data;
  logic [1:0] sel_type;
  logic slot_free, do_pop, err_set;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (int'(i) == NUM_IN - 1) ? '0 : i + 1'b1;
  endfunction

  // HEAD and SINGLE are exactly the types with the type MSB set
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_IN; i++)
      elig[i] = ~in_empty[i] & in_req[i] & in_data[i*FLIT_W + FLIT_W - 1];
  end

  rr_pick #(.N(NUM_IN), .IW(IW)) u_pick (
    .req  (elig),
    .ptr  (rr_ptr),
    .grant(pick_grant),
    .idx  (pick_idx)
  );

  assign slot_free = ~out_valid | out_ready;
  assign lock_busy = state == LOCKED;

  always_comb begin
    sel_idx = lock_busy ? owner : pick_idx;
    sel_data = in_data[sel_idx*FLIT_W +: FLIT_W];
    sel_type = sel_data[FLIT_W-1 -: 2];
    do_pop = ~rst & slot_free & (lock_busy ? ~in_empty[owner] : |elig);
    in_pop = ~do_pop ? '0 : lock_busy ? NUM_IN'(1) << owner : pick_grant;
    state_n = state;
    owner_n = owner;
    rr_n = rr_ptr;
    err_set = 1'b0;
    if (do_pop && !lock_busy) begin
      state_n = sel_type == FLIT_TYPE_HEAD ? LOCKED : IDLE;
      owner_n = sel_type == FLIT_TYPE_HEAD ? pick_idx : owner;
      rr_n = sel_type == FLIT_TYPE_SINGLE ? wrap_inc(pick_idx) : rr_ptr;
    end
    if (do_pop && lock_busy) begin
      state_n = sel_type == FLIT_TYPE_TAIL ? IDLE : LOCKED;
      rr_n = sel_type == FLIT_TYPE_TAIL ? wrap_inc(owner) : rr_ptr;
      err_set = sel_type[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr_ptr <= rr_n;
      out_valid <= do_pop | (out_valid & ~out_ready);
      if (do_pop) out_data <= sel_data;
      if (err_set) proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wormhole_out_arb.sv
// tb_wormhole_out_arb: random packet traffic against a queue-based wormhole model plus directed corner cases
module tb_wormhole_out_arb;
  import wormhole_out_arb_pkg::*;
  localparam int N = NUM_PORTS;
  localparam int FW = FLIT_LENGTH;
  localparam int PW = FW - 2;

  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b1;
  logic [N-1:0] in_empty = '1, in_req = '0, in_pop;
  logic [N*FW-1:0] in_data = '0;
  logic [FW-1:0] out_data;
  logic out_valid, lock_busy, proto_err;

  wormhole_out_arb dut (
    .clk(clk), .rst(rst), .in_empty(in_empty), .in_data(in_data), .in_req(in_req),
    .in_pop(in_pop), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .lock_busy(lock_busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [FW-1:0] q[N][$];
  bit m_locked = 0, m_valid = 0, m_err = 0;
  int m_owner = 0, m_ptr = 0;
  logic [FW-1:0] m_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t);
    return {t, PW'($urandom)};
  endfunction

  task automatic push_pkt(input int i);
    if ($urandom_range(3) == 0) q[i].push_back(mk(FLIT_TYPE_SINGLE));
    else begin
      q[i].push_back(mk(FLIT_TYPE_HEAD));
      repeat ($urandom_range(3))
        q[i].push_back(mk($urandom_range(24) == 0 ? FLIT_TYPE_HEAD : FLIT_TYPE_BODY));
      q[i].push_back(mk(FLIT_TYPE_TAIL));
    end
  endtask

  task automatic random_cycle();
    int pop;
    logic [1:0] t;
    logic [FW-1:0] f;
    bit sf;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (q[i].size() < 6 && $urandom_range(2) == 0) push_pkt(i);
      in_empty[i] = q[i].size() == 0 || $urandom_range(4) == 0;
      in_data[i*FW +: FW] = q[i].size() != 0 ? q[i][0] : FW'($urandom);
      in_req[i] = $urandom_range(3) != 0;
    end
    out_ready = $urandom_range(3) != 0;
    #1;
    sf = !m_valid || out_ready;
    pop = -1;
    if (m_locked) begin
      if (sf && !in_empty[m_owner]) pop = m_owner;
    end else if (sf) begin
      for (int k = N - 1; k >= 0; k--) begin
        int i = (m_ptr + k) % N;
        t = in_data[i*FW + FW - 2 +: 2];
        if (!in_empty[i] && in_req[i] && (t == FLIT_TYPE_HEAD || t == FLIT_TYPE_SINGLE)) pop = i;
      end
    end
    chk("pop", 64'(in_pop), pop >= 0 ? 64'(1) << pop : 64'(0));
    chk("valid", 64'(out_valid), 64'(m_valid));
    chk("data", 64'(out_data), 64'(m_data));
    chk("lock", 64'(lock_busy), 64'(m_locked));
    chk("err", 64'(proto_err), 64'(m_err));
    if (m_valid && out_ready) m_valid = 0;
    if (pop >= 0) begin
      f = q[pop].pop_front();
      t = f[FW-1:FW-2];
      m_valid = 1;
      m_data = f;
      if (!m_locked) begin
        if (t == FLIT_TYPE_HEAD) begin
          m_locked = 1;
          m_owner = pop;
        end else m_ptr = (pop + 1) % N;
      end else if (t == FLIT_TYPE_TAIL) begin
        m_locked = 0;
        m_ptr = (m_owner + 1) % N;
      end else if (t != FLIT_TYPE_BODY) m_err = 1;
    end
  endtask

  task automatic set_all(input logic [1:0] t);
    for (int i = 0; i < N; i++) in_data[i*FW +: FW] = {t, PW'(i + 8'h40)};
  endtask

  initial begin
    set_all(FLIT_TYPE_SINGLE);
    in_empty = '0;
    in_req = '1;
    #2;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_lock", 64'(lock_busy), 0);
    chk("rst_err", 64'(proto_err), 0);
    chk("rst_pop", 64'(in_pop), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_empty = '1;
    repeat (3000) random_cycle();
    // async reset clears everything, including a sticky error
    @(negedge clk);
    out_ready = 1'b1;
    in_empty = '0;
    in_req = '1;
    set_all(FLIT_TYPE_SINGLE);
    rst = 1'b1;
    #1;
    chk("rst2_valid", 64'(out_valid), 0);
    chk("rst2_lock", 64'(lock_busy), 0);
    chk("rst2_err", 64'(proto_err), 0);
    chk("rst2_pop", 64'(in_pop), 0);
    @(negedge clk);
    rst = 1'b0;
    in_empty = 5'b11011;
    in_data[2*FW +: FW] = {FLIT_TYPE_SINGLE, PW'(8'hAB)};
    #1;
    chk("single_pop", 64'(in_pop), 64'b00100);
    @(posedge clk);
    #1;
    chk("single_valid", 64'(out_valid), 1);
    chk("single_data", 64'(out_data), 64'({FLIT_TYPE_SINGLE, PW'(8'hAB)}));
    chk("single_lock", 64'(lock_busy), 0);
    @(negedge clk);
    in_empty = '0;
    set_all(FLIT_TYPE_SINGLE);
    #1;
    chk("rr_after_2", 64'(in_pop), 64'b01000);
    @(negedge clk);
    in_empty = 5'b11101;
    set_all(FLIT_TYPE_HEAD);
    #1;
    chk("head_pop", 64'(in_pop), 64'b00010);
    @(posedge clk);
    #1;
    chk("head_lock", 64'(lock_busy), 1);
    @(negedge clk);
    in_empty = '0;
    set_all(FLIT_TYPE_BODY);
    out_ready = 1'b0;
    #2;
    chk("bp_pop", 64'(in_pop), 0);
    chk("bp_data", 64'(out_data), 64'({FLIT_TYPE_HEAD, PW'(8'h41)}));
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 0);
    chk("midrst_lock", 64'(lock_busy), 0);
    chk("midrst_pop", 64'(in_pop), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    set_all(FLIT_TYPE_SINGLE);
    #1;
    chk("post_rst_pop", 64'(in_pop), 64'b00001);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
